// File: rtl/otp_cmd_sequencer_if.sv
// otp_cmd_sequencer_if: host command/response handshake plus OTP controller signals.
interface otp_cmd_sequencer_if #(
    parameter int A  = 2,
    parameter int AW = 1
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_column;
    logic [A-1:0]  cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [A-1:0]  rsp_data;
    logic [1:0]    rsp_status;
    logic [1:0]    mode;
    logic [AW-1:0] column;
    logic [A-1:0]  data_in;
    logic          writing_successful;
    logic [A-1:0]  data_out;
    logic          read_active;

    modport slave (
        input  cmd_valid, cmd_write, cmd_column, cmd_data, rsp_ready, data_out, read_active,
        output cmd_ready, rsp_valid, rsp_data, rsp_status, mode, column, data_in, writing_successful
    );

    modport master (
        output cmd_valid, cmd_write, cmd_column, cmd_data, rsp_ready, data_out, read_active,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status, mode, column, data_in, writing_successful
    );
endinterface

// File: rtl/otp_cmd_sequencer.sv
// otp_cmd_sequencer: sequences host read/program commands into OTP controller reads, pulses and verify retries.
module otp_cmd_sequencer #(
    parameter int A            = 2,
    parameter int B            = 2,
    parameter int PULSE_CYCLES = 8,
    parameter int MAX_RETRY    = 3,
    parameter int TIMEOUT      = 64
) (
    input logic clk,
    input logic reset,
    otp_cmd_sequencer_if.slave bus
);
    localparam int AW   = B > 1 ? $clog2(B) : 1;
    localparam int CMAX = TIMEOUT > PULSE_CYCLES ? TIMEOUT : PULSE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, PG_PULSE, PG_GAP, VF_WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] col_q, col_d;
    logic [A-1:0]  data_q, data_d;
    logic [A-1:0]  rdata_q, rdata_d;
    logic [1:0]    status_q, status_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          seen_q, seen_d;
    logic          waiting, done, pass, accept;

    // mode drops to 00 in the completion cycle, so a verify retry never goes 01 -> 10 directly
    assign waiting = state_q == RD_WAIT || state_q == VF_WAIT;
    assign done    = waiting && seen_q && !bus.read_active;
    assign pass    = (bus.data_out & data_q) == data_q;
    assign accept  = bus.cmd_valid && state_q == IDLE && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            status_q <= 2'b00;
            cnt_q    <= '0;
            retry_q  <= '0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            seen_q   <= seen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        seen_d   = seen_q;
        unique case (state_q)
            IDLE: if (accept) begin
                col_d    = bus.cmd_column;
                data_d   = bus.cmd_data;
                rdata_d  = '0;
                status_d = 2'b00;
                cnt_d    = '0;
                seen_d   = 1'b0;
                retry_d  = RW'(1);
                if (32'(bus.cmd_column) >= B) begin
                    state_d  = RESP;
                    status_d = 2'b10;
                end else if (!bus.cmd_write) state_d = RD_WAIT;
                else if (bus.cmd_data == '0) state_d = RESP;
                else state_d = PG_PULSE;
            end
            RD_WAIT, VF_WAIT: begin
                seen_d = seen_q | bus.read_active;
                cnt_d  = cnt_q + CW'(1);
                if (done) begin
                    rdata_d = bus.data_out;
                    if (state_q == RD_WAIT || pass) begin
                        state_d  = RESP;
                        status_d = 2'b00;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        state_d = PG_PULSE;
                        retry_d = retry_q + RW'(1);
                        cnt_d   = '0;
                    end else begin
                        state_d  = RESP;
                        status_d = 2'b01;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = RESP;
                    status_d = 2'b11;
                    rdata_d  = '0;
                end
            end
            PG_PULSE: if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
                state_d = PG_GAP;
                cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
            PG_GAP: begin
                state_d = VF_WAIT;
                cnt_d   = '0;
                seen_d  = 1'b0;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready          = state_q == IDLE && !reset;
        bus.rsp_valid          = state_q == RESP;
        bus.rsp_data           = rdata_q;
        bus.rsp_status         = status_q;
        bus.mode               = state_q == PG_PULSE ? 2'b10 : (waiting && !done) ? 2'b01 : 2'b00;
        bus.column             = col_q;
        bus.data_in            = data_q;
        bus.writing_successful = state_q == VF_WAIT && done && pass;
    end
endmodule

// File: tb/tb_otp_cmd_sequencer.sv
// tb_otp_cmd_sequencer: directed scoreboard bench with a reactive OTP controller model.
module tb_otp_cmd_sequencer;
    localparam int A = 2, B = 3, PC = 8, MR = 3, TO = 64, AW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    otp_cmd_sequencer_if #(.A(A), .AW(AW)) bus ();

    otp_cmd_sequencer #(
        .A(A), .B(B), .PULSE_CYCLES(PC), .MAX_RETRY(MR), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int compared = 0, mismatched = 0;
    logic [3:0] exp_q[$];
    logic [1:0] rb_q[$];
    logic silent = 1'b0;
    logic [1:0] exp_col = '0, exp_din = '0, pmode = '0;
    int npulse = 0, plen = 0, nws = 0, rd_run = 0, last_rd = 0, nz = 0;
    int np0, nw0, nz0;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic send(input logic w, input logic [1:0] c, input logic [1:0] d);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_column = c;
        bus.cmd_data = d;
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", int'(n < 300), 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("response_in_time", int'(n < 500), 1);
        @(negedge clk);
    endtask

    // controller model: read_active high two cycles, then low with the next read-back value
    initial begin
        int ra_cnt = 0;
        bus.read_active = 1'b0;
        bus.data_out = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && !silent && bus.mode == 2'b01) begin
                if (ra_cnt < 2) begin
                    bus.read_active = 1'b1;
                    ra_cnt++;
                end else begin
                    bus.read_active = 1'b0;
                    bus.data_out = 2'b00;
                    if (rb_q.size() > 0) bus.data_out = rb_q.pop_front();
                end
            end else begin
                bus.read_active = 1'b0;
                ra_cnt = 0;
            end
        end
    end

    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                plen = 0;
                rd_run = 0;
                pmode = 2'b00;
            end else begin
                if (bus.rsp_valid) chk("no_accept_during_resp", int'(bus.cmd_ready), 0);
                if (bus.rsp_valid && bus.rsp_ready) begin
                    chk("rsp_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rsp_data", int'(bus.rsp_data), int'(e[3:2]));
                        chk("rsp_status", int'(bus.rsp_status), int'(e[1:0]));
                    end
                end
                if (bus.mode != 2'b00) begin
                    nz++;
                    chk("column_stable", int'(bus.column), int'(exp_col));
                    chk("data_in_stable", int'(bus.data_in), int'(exp_din));
                end
                if (bus.mode != pmode)
                    chk("mode_no_direct_01_10", int'({pmode, bus.mode} == 4'b0110 || {pmode, bus.mode} == 4'b1001), 0);
                if (bus.mode == 2'b10) plen++;
                else if (pmode == 2'b10) begin
                    chk("pulse_length", plen, PC);
                    chk("gap_after_pulse", int'(bus.mode), 0);
                    npulse++;
                    plen = 0;
                end
                if (bus.mode == 2'b01) rd_run++;
                else if (pmode == 2'b01) begin
                    last_rd = rd_run;
                    rd_run = 0;
                end
                if (bus.writing_successful) nws++;
                pmode = bus.mode;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_column = '0;
        bus.cmd_data = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_mode", int'(bus.mode), 0);
        chk("reset_column", int'(bus.column), 0);
        chk("reset_data_in", int'(bus.data_in), 0);
        chk("reset_ws", int'(bus.writing_successful), 0);
        chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
        chk("reset_rsp_data", int'(bus.rsp_data), 0);
        chk("reset_rsp_status", int'(bus.rsp_status), 0);
        chk("reset_cmd_ready", int'(bus.cmd_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", int'(bus.cmd_ready), 1);

        exp_col = 2'd1; exp_din = 2'b00;
        rb_q.push_back(2'b10);
        exp_q.push_back({2'b10, 2'b00});
        send(1'b0, 2'd1, 2'b00);
        drain();

        np0 = npulse; nw0 = nws;
        exp_col = 2'd0; exp_din = 2'b11;
        rb_q.push_back(2'b01); rb_q.push_back(2'b11);
        exp_q.push_back({2'b11, 2'b00});
        send(1'b1, 2'd0, 2'b11);
        drain();
        chk("write_retry_pulses", npulse - np0, 2);
        chk("write_retry_ws", nws - nw0, 1);

        np0 = npulse; nw0 = nws;
        exp_col = 2'd2; exp_din = 2'b01;
        repeat (3) rb_q.push_back(2'b00);
        exp_q.push_back({2'b00, 2'b01});
        send(1'b1, 2'd2, 2'b01);
        drain();
        chk("verify_fail_pulses", npulse - np0, MR);
        chk("verify_fail_ws", nws - nw0, 0);

        nz0 = nz;
        exp_q.push_back({2'b00, 2'b10});
        send(1'b0, 2'd3, 2'b00);
        chk("bad_col_resp_next", int'(bus.rsp_valid), 1);
        chk("bad_col_status", int'(bus.rsp_status), 2);
        @(negedge clk);
        chk("resp_one_clock", int'(bus.rsp_valid), 0);
        drain();
        chk("bad_col_mode_idle", nz - nz0, 0);

        nz0 = nz;
        exp_q.push_back({2'b00, 2'b00});
        send(1'b1, 2'd1, 2'b00);
        drain();
        chk("zero_write_no_pulse", nz - nz0, 0);

        silent = 1'b1;
        exp_col = 2'd0; exp_din = 2'b00;
        exp_q.push_back({2'b00, 2'b11});
        send(1'b0, 2'd0, 2'b00);
        drain();
        chk("timeout_wait_cycles", last_rd, TO);
        silent = 1'b0;

        bus.rsp_ready = 1'b0;
        rb_q.push_back(2'b01);
        exp_q.push_back({2'b01, 2'b00});
        send(1'b0, 2'd0, 2'b00);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", int'(bus.rsp_valid), 1);
            chk("hold_rsp_data", int'(bus.rsp_data), 1);
            chk("hold_rsp_status", int'(bus.rsp_status), 0);
        end
        bus.rsp_ready = 1'b1;
        drain();

        exp_col = 2'd0; exp_din = 2'b11;
        send(1'b1, 2'd0, 2'b11);
        chk("pulse_started", int'(bus.mode), 2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_abort_mode", int'(bus.mode), 0);
        chk("reset_abort_rsp", int'(bus.rsp_valid), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        exp_col = 2'd1; exp_din = 2'b00;
        rb_q.push_back(2'b11);
        exp_q.push_back({2'b11, 2'b00});
        send(1'b0, 2'd1, 2'b00);
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/otp_cmd_sequencer.md
OTP_CMD_SEQUENCER -- requirements
Module: otp_cmd_sequencer

Interface
REQ-001 Parameter A, default 2: data word width in bits.
REQ-002 Parameter B, default 2: number of OTP columns; ADDR_WIDTH = max(1, ceil(log2(B))).
REQ-003 Parameter PULSE_CYCLES, default 8: program-pulse length in clocks, minimum 1.
REQ-004 Parameter MAX_RETRY, default 3: maximum program pulses per write, minimum 1.
REQ-005 Parameter TIMEOUT, default 64: maximum clocks allowed per controller read.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cmd_valid / cmd_ready  in / out  1 / 1  host command handshake.
REQ-009 cmd_write  in  1  1 = program, 0 = read.
REQ-010 cmd_column  in  ADDR_WIDTH  target column.
REQ-011 cmd_data  in  A  bits to program; 1 = blow fuse.
REQ-012 rsp_valid / rsp_ready  out / in  1 / 1  host response handshake.
REQ-013 rsp_data  out  A  read data, or final verify read-back.
REQ-014 rsp_status  out  2  00 OK, 01 VERIFY_FAIL, 10 BAD_COLUMN, 11 TIMEOUT.
REQ-015 mode  out  2  to controller: 00 IDLE, 01 READ, 10 PROGRAM.
REQ-016 column / data_in  out  ADDR_WIDTH / A  to controller; held stable while mode != 00.
REQ-017 writing_successful  out  1  to controller; one-clock pulse on verify pass.
REQ-018 data_out / read_active  in  A / 1  from controller.

Function
REQ-019 States SHALL be IDLE, RD_WAIT, PG_PULSE, PG_GAP, VF_WAIT, RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid && cmd_ready, and column, data and write flag are latched.
REQ-021 Accepted command with cmd_column >= B: go to RESP with status 10 and rsp_data 0; mode stays 00.
REQ-022 Accepted read: go to RD_WAIT, drive mode=01.
REQ-023 Accepted write with cmd_data == 0: go to RESP with status 00; no pulse is issued.
REQ-024 Accepted write otherwise: go to PG_PULSE with retry counter = 1.
REQ-025 RD_WAIT/VF_WAIT: hold mode=01; a read completes in the first cycle read_active is 0 after having been 1 during this wait; data_out is captured in that cycle.
REQ-026 Wait counter starts at 0 on wait entry; if it reaches TIMEOUT before completion, go to RESP with status 11, rsp_data 0, mode 00.
REQ-027 PG_PULSE: drive mode=10 for exactly PULSE_CYCLES clocks, then go to PG_GAP.
REQ-028 PG_GAP: drive mode=00 for exactly 1 clock, then go to VF_WAIT.
REQ-029 Verify passes iff (captured & latched_data) == latched_data.
REQ-030 On pass: pulse writing_successful for the completion cycle, then go to RESP with status 00.
REQ-031 On fail with retry counter < MAX_RETRY: increment the counter and go to PG_PULSE.
REQ-032 On fail with retry counter == MAX_RETRY: go to RESP with status 01.
REQ-033 RESP: mode=00, rsp_valid=1, and rsp_data/rsp_status held stable until rsp_ready; then go to IDLE.
REQ-034 RESP with rsp_ready already 1 on entry: RESP lasts exactly one clock.
REQ-035 Minimum spacing: a new command is not accepted in the same cycle a response completes.
REQ-036 mode SHALL never change directly between 01 and 10 without at least one 00 cycle.

Reset
REQ-037 When reset=1 at a clock edge: state=IDLE, mode=00, column=0, data_in=0, writing_successful=0, rsp_valid=0, rsp_data=0, rsp_status=00, cmd_ready=0 during the reset cycle, all counters 0.
REQ-038 Reset mid-pulse or mid-read aborts the operation with no response; mode=00 the cycle after the reset edge.

Verification
REQ-039 Read col 1, controller reads data_out=2'b10 → mode=01 until read_active falls; rsp {data=10, status=00}.
REQ-040 Write col 0 data=11; first read-back 01, second 11 → two 8-clock mode=10 pulses, each followed by a 00 gap; writing_successful pulses once; status 00.
REQ-041 Write data=01; read-back always 00 → exactly 3 pulses, then status 01 with rsp_data=00.
REQ-042 Command with column=2 when B=2 → status 10 in RESP the cycle after accept; mode never leaves 00.
REQ-043 read_active held 0 during read → status 11 after 64 clocks in RD_WAIT.
REQ-044 Assert reset during the 4th clock of PG_PULSE → mode=00 next cycle, no rsp_valid; a new read then completes normally.
